// File: rtl/iob_sync_fifo_ctrl_pkg.sv
// iob_sync_fifo_ctrl_pkg: shared FIFO defaults (iob_fifo_defs) and depth helper
// No ports; imported by the interface, pointer and top files.
package iob_sync_fifo_ctrl_pkg;
  localparam int IOB_FIFO_DATA_W = 8;
  localparam int IOB_FIFO_ADDR_W = 5;
  function automatic int iob_fifo_depth(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/iob_sync_fifo_ctrl_if.sv
// iob_sync_fifo_ctrl_if: push/pop/status bundle of the FIFO controller
// master: drives w_en/w_data/r_en and observes status; slave: the controller.
interface iob_sync_fifo_ctrl_if
  import iob_sync_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W = IOB_FIFO_DATA_W,
  parameter int ADDR_W = IOB_FIFO_ADDR_W
);
  logic              w_en;
  logic [DATA_W-1:0] w_data;
  logic              full;
  logic              r_en;
  logic [DATA_W-1:0] r_data;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              underflow;
  modport master (
    output w_en, w_data, r_en,
    input  full, r_data, empty, level, overflow, underflow
  );
  modport slave (
    input  w_en, w_data, r_en,
    output full, r_data, empty, level, overflow, underflow
  );
endinterface

// File: rtl/iob_fifo_ptr.sv
// iob_fifo_ptr: wrapping ADDR_W-bit pointer, advances by one when en_i is high
// Ports: clk, rst (async, active-high), en_i increment enable, ptr_o pointer value.
module iob_fifo_ptr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] ptr_o
);
  logic [W-1:0] ptr_q, ptr_d;
  always_comb ptr_d = en_i ? ptr_q + 1'b1 : ptr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
  assign ptr_o = ptr_q;
endmodule

// File: rtl/iob_sync_fifo_ctrl.sv
// iob_sync_fifo_ctrl: synchronous FIFO controller driving an external 2-port RAM
// Ports: clk, rst (async, active-high); bus (slave) push/pop/status;
// ext_mem_w_* RAM write port, ext_mem_r_* RAM read port (1-cycle registered read).
// Macro IOB_FIFO_ERR_FLAGS_EN enables sticky overflow/underflow flags.
module iob_sync_fifo_ctrl
  import iob_sync_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W = IOB_FIFO_DATA_W,
  parameter int ADDR_W = IOB_FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  iob_sync_fifo_ctrl_if.slave bus,
  output logic              ext_mem_w_en,
  output logic [ADDR_W-1:0] ext_mem_w_addr,
  output logic [DATA_W-1:0] ext_mem_w_data,
  output logic              ext_mem_r_en,
  output logic [ADDR_W-1:0] ext_mem_r_addr,
  input  logic [DATA_W-1:0] ext_mem_r_data
);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(iob_fifo_depth(ADDR_W));
  logic [ADDR_W:0]   level_q, level_d;
  logic [ADDR_W-1:0] w_ptr, r_ptr;
  logic              full, empty, push, pop;
  always_comb full = level_q == DEPTH;
  always_comb empty = level_q == '0;
  // rst gating keeps the RAM enables low for the whole reset pulse
  always_comb push = bus.w_en & ~full & ~rst;
  always_comb pop = bus.r_en & ~empty & ~rst;
  always_comb level_d = (push & ~pop) ? level_q + 1'b1 :
                        (pop & ~push) ? level_q - 1'b1 : level_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) level_q <= '0;
    else level_q <= level_d;
  iob_fifo_ptr #(.W(ADDR_W)) u_w_ptr (.clk(clk), .rst(rst), .en_i(push), .ptr_o(w_ptr));
  iob_fifo_ptr #(.W(ADDR_W)) u_r_ptr (.clk(clk), .rst(rst), .en_i(pop), .ptr_o(r_ptr));
  assign ext_mem_w_en   = push;
  assign ext_mem_w_addr = w_ptr;
  assign ext_mem_w_data = bus.w_data;
  assign ext_mem_r_en   = pop;
  assign ext_mem_r_addr = r_ptr;
  assign bus.r_data     = ext_mem_r_data;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.level      = level_q;
`ifdef IOB_FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d, unf_q, unf_d;
  always_comb ovf_d = ovf_q | (bus.w_en & full);
  always_comb unf_d = unf_q | (bus.r_en & empty);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_iob_sync_fifo_ctrl.sv
// tb_iob_sync_fifo_ctrl: directed self-checking bench with a behavioural 2-port RAM
module tb_iob_sync_fifo_ctrl;
  localparam int DW = 8;
  localparam int AW = 5;
`ifdef IOB_FIFO_ERR_FLAGS_EN
  localparam logic FLG = 1'b1;
`else
  localparam logic FLG = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mw_en, mr_en;
  logic [AW-1:0] mw_addr, mr_addr;
  logic [DW-1:0] mw_data, mr_data;
  logic [DW-1:0] mem [2**AW];
  int n_cmp = 0;
  int n_bad = 0;
  iob_sync_fifo_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  iob_sync_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ext_mem_w_en(mw_en), .ext_mem_w_addr(mw_addr), .ext_mem_w_data(mw_data),
    .ext_mem_r_en(mr_en), .ext_mem_r_addr(mr_addr), .ext_mem_r_data(mr_data)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mw_en) mem[mw_addr] <= mw_data;
    if (mr_en) mr_data <= mem[mr_addr];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [DW-1:0] d);
    bus.w_en = 1'b1;
    bus.w_data = d;
    tick();
    bus.w_en = 1'b0;
  endtask
  task automatic pop_chk(input string tag, input logic [DW-1:0] exp);
    bus.r_en = 1'b1;
    tick();
    bus.r_en = 1'b0;
    chk(tag, 32'(bus.r_data), 32'(exp));
  endtask
  function automatic logic [DW-1:0] fv(input int i);
    return DW'(i * 3 + 1);
  endfunction
  function automatic logic [DW-1:0] sv(input int i);
    return DW'(i * 7 + 3);
  endfunction
  initial begin
    bus.w_en = 1'b1;
    bus.r_en = 1'b1;
    bus.w_data = 8'h99;
    repeat (2) tick();
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_mw_en", 32'(mw_en), 0);
    chk("rst_mr_en", 32'(mr_en), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_unf", 32'(bus.underflow), 0);
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    rst = 1'b0;
    tick();
    chk("idle_level", 32'(bus.level), 0);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    chk("p3_level", 32'(bus.level), 3);
    chk("p3_empty", 32'(bus.empty), 0);
    pop_chk("pop_11", 8'h11);
    pop_chk("pop_22", 8'h22);
    pop_chk("pop_33", 8'h33);
    chk("p3_end_empty", 32'(bus.empty), 1);
    chk("p3_end_level", 32'(bus.level), 0);
    for (int i = 0; i < 32; i++) push(fv(i));
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_level", 32'(bus.level), 32);
    bus.w_en = 1'b1;
    bus.w_data = 8'hEE;
    #1;
    chk("ovf_mw_en", 32'(mw_en), 0);
    tick();
    bus.w_en = 1'b0;
    chk("ovf_level", 32'(bus.level), 32);
    chk("ovf_flag", 32'(bus.overflow), 32'(FLG));
    bus.w_en = 1'b1;
    bus.r_en = 1'b1;
    bus.w_data = 8'h77;
    #1;
    chk("fb_mw_en", 32'(mw_en), 0);
    chk("fb_mr_en", 32'(mr_en), 1);
    tick();
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    chk("fb_rdata", 32'(bus.r_data), 32'(fv(0)));
    chk("fb_level", 32'(bus.level), 31);
    chk("fb_full", 32'(bus.full), 0);
    for (int i = 1; i < 32; i++) pop_chk($sformatf("drain_%0d", i), fv(i));
    chk("drain_empty", 32'(bus.empty), 1);
    chk("drain_unf", 32'(bus.underflow), 0);
    bus.w_en = 1'b1;
    bus.r_en = 1'b1;
    bus.w_data = 8'hA5;
    #1;
    chk("eb_mw_en", 32'(mw_en), 1);
    chk("eb_mr_en", 32'(mr_en), 0);
    tick();
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    chk("eb_level", 32'(bus.level), 1);
    chk("eb_unf", 32'(bus.underflow), 32'(FLG));
    chk("eb_ovf_sticky", 32'(bus.overflow), 32'(FLG));
    pop_chk("eb_pop_a5", 8'hA5);
    push(sv(0));
    for (int k = 0; k < 100; k++) begin
      bus.w_en = 1'b1;
      bus.r_en = 1'b1;
      bus.w_data = sv(k + 1);
      tick();
      chk($sformatf("stream_%0d", k), 32'(bus.r_data), 32'(sv(k)));
      chk($sformatf("stream_lvl_%0d", k), 32'(bus.level), 1);
    end
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    pop_chk("stream_last", sv(100));
    chk("stream_empty", 32'(bus.empty), 1);
    for (int i = 0; i < 10; i++) push(8'hC0 + 8'(i));
    chk("pre_rst_level", 32'(bus.level), 10);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_level", 32'(bus.level), 0);
    chk("arst_empty", 32'(bus.empty), 1);
    chk("arst_full", 32'(bus.full), 0);
    chk("arst_ovf", 32'(bus.overflow), 0);
    chk("arst_unf", 32'(bus.underflow), 0);
    tick();
    rst = 1'b0;
    bus.r_en = 1'b1;
    #1;
    chk("post_rst_mr_en", 32'(mr_en), 0);
    tick();
    bus.r_en = 1'b0;
    chk("post_rst_level", 32'(bus.level), 0);
    push(8'h5C);
    pop_chk("post_rst_pop", 8'h5C);
    chk("post_rst_empty", 32'(bus.empty), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/iob_sync_fifo_ctrl.md
IOB_SYNC_FIFO_CTRL -- requirements
Module: iob_sync_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, RAM address width; depth = 2^ADDR_W.
REQ-003 SHALL use one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 w_en  input  1  push request.
REQ-006 w_data  input  DATA_W  push data.
REQ-007 full  output  1  FIFO holds 2^ADDR_W entries.
REQ-008 r_en  input  1  pop request.
REQ-009 r_data  output  DATA_W  pop data, valid one cycle after an accepted pop.
REQ-010 empty  output  1  FIFO holds 0 entries.
REQ-011 level  output  ADDR_W+1  current occupancy.
REQ-012 ext_mem_w_en, ext_mem_w_addr (ADDR_W), ext_mem_w_data (DATA_W)  outputs  drive the 2-port RAM write port.
REQ-013 ext_mem_r_en, ext_mem_r_addr (ADDR_W)  outputs; ext_mem_r_data (DATA_W) input; RAM read port with 1-cycle registered read.
REQ-014 overflow, underflow  output  1 each  sticky error flags (see REQ-030).

Function
REQ-015 Push accepted iff w_en=1 and full=0; ext_mem_w_en = accepted push, ext_mem_w_addr = w_ptr, ext_mem_w_data = w_data, all combinational.
REQ-016 Pop accepted iff r_en=1 and empty=0; ext_mem_r_en = accepted pop, ext_mem_r_addr = r_ptr, combinational.
REQ-017 r_data SHALL be ext_mem_r_data passed through; value valid exactly 1 cycle after the accepting edge, held until next accepted pop.
REQ-018 w_ptr, r_ptr (ADDR_W bits) SHALL increment by 1 per accepted push/pop, wrapping 2^ADDR_W-1 -> 0.
REQ-019 level SHALL update per edge: +1 push only, -1 pop only, unchanged on both or neither.
REQ-020 full = (level == 2^ADDR_W); empty = (level == 0); both derived from registered level, no combinational path from w_en/r_en.
REQ-021 Full with push and pop same cycle: pop accepted, push rejected; level becomes 2^ADDR_W-1.
REQ-022 Empty with push and pop same cycle: push accepted, pop rejected; level becomes 1; first-written data poppable next cycle.
REQ-023 Rejected requests SHALL not change pointers, level, or RAM.
REQ-024 Data SHALL be popped in push order; no loss or duplication across pointer wrap.

Reset
REQ-025 On rst=1, immediately and regardless of clk: w_ptr=0, r_ptr=0, level=0, empty=1, full=0, overflow=0, underflow=0.
REQ-026 ext_mem_w_en and ext_mem_r_en SHALL be 0 while rst=1.
REQ-027 Reset mid-operation SHALL discard all contents; RAM contents are not cleared and are never returned.
REQ-028 r_data after reset is undefined until the first accepted pop completes.

Configuration
REQ-029 Macro IOB_FIFO_ERR_FLAGS_EN selects error-flag logic.
REQ-030 With macro defined: overflow set on first rejected push (w_en=1, full=1), underflow set on first rejected pop (r_en=1, empty=1); both sticky until rst.
REQ-031 Without macro: overflow and underflow tied 0, no flag registers synthesized; all other behaviour identical.

Structure
REQ-032 Shared include iob_fifo_defs SHALL hold default DATA_W/ADDR_W and the depth constant expression (1<<ADDR_W).
REQ-033 Pointer logic SHALL be one sub-module iob_fifo_ptr (ADDR_W counter, increment enable, wrap), instantiated twice; the 2-port RAM stays outside this block.

Verification
REQ-034 Reset, push 0x11,0x22,0x33, pop 3 -> r_data 0x11,0x22,0x33 on cycles after each pop; empty=1, level=0 at end.
REQ-035 Push 32 values (ADDR_W=5) -> full=1, level=32; 33rd push -> ignored, overflow=1 (macro on) / 0 (macro off).
REQ-036 Full, assert w_en and r_en together -> oldest value popped, level=31, full=0, write not performed.
REQ-037 Empty, assert w_en=0xA5 and r_en together -> level=1, underflow=1 (macro on); next-cycle pop returns 0xA5.
REQ-038 Continuous push/pop for 100 entries across 3 pointer wraps -> output sequence equals input sequence, level constant.
REQ-039 Assert rst asynchronously with level=10 -> level=0, empty=1, flags 0 before next clk edge.
